cus42_vram_arbiter: RTL and testbench



---
 rtl/system86_vram_defs.sv | 17 +
 rtl/cus42_vram_slot_decode.sv | 18 +
 rtl/cus42_vram_arbiter.sv | 162 ++++++++++++++++
 tb/tb_cus42_vram_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/system86_vram_defs.sv
// Shared definitions for the System 86 tilemap VRAM arbiter: geometry, CPU FSM
// encodings and video slot ownership.
package system86_vram_defs;

   localparam int VRAM_DATA_W    = 8;
   localparam int LAYER_PAGE_BIT = 12;
   localparam int VRAM_ADDR_W    = LAYER_PAGE_BIT + 1;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_WAIT   = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   // Layer 0 owns the video slot when H[1] equals this value.
   localparam logic L0_OWNER_H1 = 1'b1;

endpackage

// File: rtl/cus42_vram_slot_decode.sv
// Decodes the pixel-clock phase and H[1] into slot type and video slot owner.
module cus42_vram_slot_decode
   import system86_vram_defs::*;
(
   input  logic       pix_ce_i,
   input  logic [1:0] h_i,
   output logic       video_slot_o,
   output logic       cpu_slot_o,
   output logic       l0_owner_o,
   output logic       l1_owner_o
);

   assign video_slot_o = pix_ce_i;
   assign cpu_slot_o   = ~pix_ce_i;
   assign l0_owner_o   = pix_ce_i & (h_i[1] == L0_OWNER_H1);
   assign l1_owner_o   = pix_ce_i & (h_i[1] != L0_OWNER_H1);

endmodule

// File: rtl/cus42_vram_arbiter.sv
// Time-division arbiter: video slots feed the two scroll layers, CPU slots serve a
// request/ack FSM. Define CUS42_VRAM_POSTED_WRITE_EN for a one-entry posted write buffer.
module cus42_vram_arbiter
   import system86_vram_defs::*;
#(
   parameter int ADDR_W = VRAM_ADDR_W,
   parameter int DATA_W = VRAM_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pix_ce,
   input  logic [1:0]        H,
   input  logic [ADDR_W-2:0] l0_ra,
   input  logic [ADDR_W-2:0] l1_ra,
   output logic [DATA_W-1:0] l0_rd,
   output logic [DATA_W-1:0] l1_rd,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ack,
   output logic [ADDR_W-1:0] sram_a,
   input  logic [DATA_W-1:0] sram_din,
   output logic [DATA_W-1:0] sram_dout,
   output logic              sram_we_n,
   output logic              sram_oe_n
);

   logic              video_slot, cpu_slot, l0_owner, l1_owner;
   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d, sram_a_q;
   logic              we_q, we_d, pix_ce_q, cpu_ack_q;
   logic [DATA_W-1:0] wdata_q, wdata_d, rd_src;
   logic [DATA_W-1:0] l0_rd_q, l1_rd_q, cpu_rdata_q, cpu_rdata_d;
   logic              do_access, buf_full;

   cus42_vram_slot_decode u_slot (
      .pix_ce_i     (pix_ce),
      .h_i          (H),
      .video_slot_o (video_slot),
      .cpu_slot_o   (cpu_slot),
      .l0_owner_o   (l0_owner),
      .l1_owner_o   (l1_owner)
   );

   assign do_access = (state_q == ST_ACCESS) && cpu_slot;

`ifdef CUS42_VRAM_POSTED_WRITE_EN
   logic              pw_valid_q, pw_valid_d, drain;
   logic [ADDR_W-1:0] pw_addr_q, pw_addr_d;
   logic [DATA_W-1:0] pw_data_q, pw_data_d;

   assign buf_full = pw_valid_q;
   assign drain    = pw_valid_q && cpu_slot && (state_q != ST_ACCESS);
   // A read hitting the buffered address must see the not-yet-drained data.
   assign rd_src   = (pw_valid_q && (pw_addr_q == addr_q)) ? pw_data_q : sram_din;
`else
   assign buf_full = 1'b0;
   assign rd_src   = sram_din;
`endif

   always_comb begin : fsm_next
      state_d = state_q;
      addr_d  = addr_q;
      we_d    = we_q;
      wdata_d = wdata_q;
`ifdef CUS42_VRAM_POSTED_WRITE_EN
      pw_valid_d = drain ? 1'b0 : pw_valid_q;
      pw_addr_d  = pw_addr_q;
      pw_data_d  = pw_data_q;
`endif
      case (state_q)
         ST_IDLE: if (cpu_req && !buf_full) begin
            addr_d  = cpu_addr;
            we_d    = cpu_we;
            wdata_d = cpu_wdata;
            state_d = ST_WAIT;
`ifdef CUS42_VRAM_POSTED_WRITE_EN
            if (cpu_we) begin
               pw_valid_d = 1'b1;
               pw_addr_d  = cpu_addr;
               pw_data_d  = cpu_wdata;
               state_d    = ST_DONE;
            end
`endif
         end
         // A video slot that follows a CPU slot guarantees the next cycle is a CPU slot.
         ST_WAIT:   if (video_slot && !pix_ce_q) state_d = ST_ACCESS;
         ST_ACCESS: state_d = cpu_slot ? ST_DONE : ST_WAIT;
         default:   if (!cpu_req) state_d = ST_IDLE;
      endcase
   end

   always_comb begin : sram_drive
      sram_a    = sram_a_q;
      sram_dout = wdata_q;
      sram_oe_n = 1'b1;
      sram_we_n = 1'b1;
      if (rst) begin
         sram_a    = '0;
         sram_dout = '0;
      end else if (video_slot) begin
         sram_a    = l0_owner ? {1'b0, l0_ra} : {1'b1, l1_ra};
         sram_oe_n = 1'b0;
      end else if (do_access) begin
         sram_a    = addr_q;
         sram_oe_n = we_q;
         sram_we_n = ~we_q;
`ifdef CUS42_VRAM_POSTED_WRITE_EN
      end else if (drain) begin
         sram_a    = pw_addr_q;
         sram_dout = pw_data_q;
         sram_we_n = 1'b0;
`endif
      end
   end

   assign cpu_rdata_d = (do_access && !we_q) ? rd_src : cpu_rdata_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         we_q        <= 1'b0;
         wdata_q     <= '0;
         pix_ce_q    <= 1'b0;
         sram_a_q    <= '0;
         l0_rd_q     <= '0;
         l1_rd_q     <= '0;
         cpu_rdata_q <= '0;
         cpu_ack_q   <= 1'b0;
`ifdef CUS42_VRAM_POSTED_WRITE_EN
         pw_valid_q  <= 1'b0;
         pw_addr_q   <= '0;
         pw_data_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         we_q        <= we_d;
         wdata_q     <= wdata_d;
         pix_ce_q    <= pix_ce;
         sram_a_q    <= sram_a;
         cpu_rdata_q <= cpu_rdata_d;
         cpu_ack_q   <= (state_d == ST_DONE) && (state_q != ST_DONE);
         if (l0_owner) l0_rd_q <= sram_din;
         if (l1_owner) l1_rd_q <= sram_din;
`ifdef CUS42_VRAM_POSTED_WRITE_EN
         pw_valid_q  <= pw_valid_d;
         pw_addr_q   <= pw_addr_d;
         pw_data_q   <= pw_data_d;
`endif
      end
   end

   assign l0_rd     = l0_rd_q;
   assign l1_rd     = l1_rd_q;
   assign cpu_rdata = cpu_rdata_q;
   assign cpu_ack   = cpu_ack_q;

endmodule

// File: tb/tb_cus42_vram_arbiter.sv
// Bench for cus42_vram_arbiter: SRAM model, free-running pixel timing, random CPU
// traffic with a queued expected-response scoreboard and a layer capture model.
module tb_cus42_vram_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pix_ce, cpu_req, cpu_we, cpu_ack, sram_we_n, sram_oe_n;
   logic [1:0]  H;
   logic [11:0] l0_ra, l1_ra;
   logic [12:0] cpu_addr, sram_a;
   logic [7:0]  cpu_wdata, cpu_rdata, l0_rd, l1_rd, sram_din, sram_dout;

   logic [7:0]  mem [8192];
   logic [7:0]  ref_mem [8192];
   int          cyc, checks, errors, wr_count, we_viol, exp_writes;
   bit          stuck = 1'b0, rand_ra = 1'b0, mon_en = 1'b0;

   typedef struct {
      int          ack;
      bit          we;
      bit          chk;
      logic [12:0] addr;
      logic [7:0]  wdata;
   } op_t;
   op_t        op_q[$];
   logic [7:0] exp_q[$];

   cus42_vram_arbiter dut (
      .clk(clk), .rst(rst), .pix_ce(pix_ce), .H(H),
      .l0_ra(l0_ra), .l1_ra(l1_ra), .l0_rd(l0_rd), .l1_rd(l1_rd),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
      .sram_a(sram_a), .sram_din(sram_din), .sram_dout(sram_dout),
      .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
   );

   always #5 clk = ~clk;
   assign sram_din = mem[sram_a];

   function automatic logic [7:0] init_val(input int i);
      if (i == 16) return 8'hC3;
      return 8'(i * 29 + (i >> 4)) ^ 8'h3A;
   endfunction

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
      end
   endfunction

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Pixel timing: alternate video/CPU slots, H advances at each video slot.
   initial begin : pixel_gen
      pix_ce = 1'b0; H = 2'd0; l0_ra = 12'h123; l1_ra = 12'h045; cyc = 0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (stuck) pix_ce = 1'b1;
         else begin
            pix_ce = ~pix_ce;
            if (pix_ce) begin
               H = H + 2'd1;
               if (rand_ra) begin
                  l0_ra = 12'($urandom);
                  l1_ra = 12'($urandom);
               end
            end
         end
      end
   end

   // Asynchronous SRAM: writes commit mid-cycle while the strobe is low.
   initial begin : sram_model
      for (int i = 0; i < 8192; i++) mem[i] = init_val(i);
      forever begin
         @(negedge clk);
         if (sram_we_n === 1'b0) begin
            if (pix_ce) we_viol++;
            mem[sram_a] = sram_dout;
            wr_count++;
         end
      end
   end

   initial begin : monitor
      logic [12:0] a;
      logic [7:0]  e_l0, e_l1, n_l0, n_l1;
      e_l0 = 8'h00; e_l1 = 8'h00;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            check("l0_rd", 32'(l0_rd), 32'(e_l0));
            check("l1_rd", 32'(l1_rd), 32'(e_l1));
         end
         n_l0 = e_l0; n_l1 = e_l1;
         if (rst) begin
            n_l0 = 8'h00; n_l1 = 8'h00;
         end else if (pix_ce) begin
            a = H[1] ? {1'b0, l0_ra} : {1'b1, l1_ra};
            if (mon_en) begin
               check("video_sram_a", 32'(sram_a), 32'(a));
               check("video_oe_n", 32'(sram_oe_n), 32'd0);
               check("video_we_n", 32'(sram_we_n), 32'd1);
            end
            if (H[1]) n_l0 = mem[a];
            else      n_l1 = mem[a];
         end
         e_l0 = n_l0; e_l1 = n_l1;
         if (op_q.size() > 0) begin
            if (op_q[0].chk && cyc == op_q[0].ack - 1) begin
               check("access_sram_a", 32'(sram_a), 32'(op_q[0].addr));
               check("access_we_n", 32'(sram_we_n), 32'(!op_q[0].we));
               check("access_oe_n", 32'(sram_oe_n), 32'(op_q[0].we));
               if (op_q[0].we) check("access_dout", 32'(sram_dout), 32'(op_q[0].wdata));
            end
            if (cyc == op_q[0].ack) begin
               check("cpu_ack", 32'(cpu_ack), 32'd1);
               if (!op_q[0].we) check("cpu_rdata", 32'(cpu_rdata), 32'(exp_q[0]));
               void'(op_q.pop_front());
               void'(exp_q.pop_front());
            end else if (cpu_ack) check("unexpected_ack", 32'(cpu_ack), 32'd0);
         end else if (cpu_ack) check("unexpected_ack", 32'(cpu_ack), 32'd0);
      end
   end

   // Access lands in the first CPU slot that follows a full video slot at least
   // one cycle after the request is latched; the ack comes one cycle later.
   task automatic cpu_op(input bit we, input logic [12:0] addr, input logic [7:0] data,
                         input int hold);
      int  t;
      op_t op;
      t = cyc;
      op.ack = pix_ce ? t + 4 : t + 3;
      op.chk = 1'b1;
`ifdef CUS42_VRAM_POSTED_WRITE_EN
      if (we) begin
         op.ack = t + 1;
         op.chk = 1'b0;
      end
`endif
      op.we = we; op.addr = addr; op.wdata = data;
      exp_q.push_back(ref_mem[addr]);
      op_q.push_back(op);
      if (we) begin
         ref_mem[addr] = data;
         exp_writes++;
      end
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = data;
      step();
      cpu_addr = 13'($urandom); cpu_wdata = 8'($urandom); cpu_we = 1'($urandom);
      repeat (op.ack - t - 1) step();
      repeat (1 + hold) step();
      cpu_req = 1'b0;
      step();
   endtask

   initial begin : driver
      int          w0, t, mism;
      logic [12:0] a;
      checks = 0; errors = 0; wr_count = 0; we_viol = 0; exp_writes = 0;
      for (int i = 0; i < 8192; i++) ref_mem[i] = init_val(i);
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      repeat (3) step();
      @(negedge clk);
      check("rst_l0_rd", 32'(l0_rd), 32'd0);
      check("rst_l1_rd", 32'(l1_rd), 32'd0);
      check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
      check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
      check("rst_we_n", 32'(sram_we_n), 32'd1);
      check("rst_oe_n", 32'(sram_oe_n), 32'd1);
      check("rst_sram_a", 32'(sram_a), 32'd0);
      check("rst_dout", 32'(sram_dout), 32'd0);
      step();
      rst = 1'b0;
      mon_en = 1'b1;
      repeat (12) step();

      while (pix_ce !== 1'b1) step();
      w0 = wr_count;
      cpu_op(1'b1, 13'h1ABC, 8'h5A, 0);
      check("write_strobes", 32'(wr_count - w0), 32'd1);
      check("mem_1abc", 32'(mem[13'h1ABC]), 32'h5A);
      cpu_op(1'b0, 13'h0010, 8'h00, 0);

      cpu_op(1'b0, 13'h0005, 8'h00, 6);
      cpu_op(1'b0, 13'h0005, 8'h00, 0);

      rand_ra = 1'b1;
      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 2)) step();
         a = 13'($urandom_range(0, 15)) | ($urandom_range(0, 1) == 1 ? 13'h1000 : 13'h0000);
         cpu_op(1'($urandom), a, 8'($urandom), $urandom_range(0, 2));
      end

`ifndef CUS42_VRAM_POSTED_WRITE_EN
      while (pix_ce !== 1'b0) step();
      t = cyc;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0777; cpu_wdata = ~ref_mem[13'h0777];
      step();
      step();
      rst = 1'b1; cpu_req = 1'b0;
      @(negedge clk);
      check("rst_access_we_n", 32'(sram_we_n), 32'd1);
      step();
      rst = 1'b0;
      @(negedge clk);
      check("rst_after_we_n", 32'(sram_we_n), 32'd1);
      check("rst_after_ack", 32'(cpu_ack), 32'd0);
      check("rst_access_cycle", 32'(cyc - t), 32'd3);
      check("rst_mem_777", 32'(mem[13'h0777]), 32'(ref_mem[13'h0777]));
      step();
      cpu_op(1'b0, 13'h0777, 8'h00, 0);
`endif

      while (pix_ce !== 1'b1) step();
      stuck = 1'b1;
      step();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0003;
      exp_q.push_back(ref_mem[13'h0003]);
      repeat (20) step();
      stuck = 1'b0;
      op_q.push_back('{ack: cyc + 4, we: 1'b0, chk: 1'b1, addr: 13'h0003, wdata: 8'h00});
      repeat (5) step();
      cpu_req = 1'b0;
      repeat (2) step();

`ifdef CUS42_VRAM_POSTED_WRITE_EN
      w0 = wr_count;
      cpu_op(1'b1, 13'h0200, 8'h77, 0);
      cpu_op(1'b0, 13'h0200, 8'h00, 0);
      check("posted_write_count", 32'(wr_count - w0), 32'd1);
`endif

      repeat (6) step();
      mism = 0;
      for (int i = 0; i < 8192; i++) if (mem[i] !== ref_mem[i]) mism++;
      check("mem_image", 32'(mism), 32'd0);
      check("we_in_video_slot", 32'(we_viol), 32'd0);
      check("total_writes", 32'(wr_count), 32'(exp_writes));
      check("pending_ops", 32'(op_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
